// File: rtl/key_entry.sv
// Keypad entry controller: debounces scanner presses and assembles 4-digit BCD PINs.
// Digits shift in from the right; '#' completes a full entry and '*' clears it.
module key_entry #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] entry,
    output logic [2:0]  entry_cnt,
    output logic [15:0] pin_out,
    output logic        pin_ready,
    output logic        key_accept,
    output logic        key_err
);

    localparam logic [15:0] DB_LIMIT  = 16'(DEBOUNCE_CYCLES);
    localparam logic [3:0]  CODE_STAR = 4'd13;
    localparam logic [3:0]  CODE_HASH = 4'd14;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD
    } state_t;

    state_t      state, state_nx;
    logic [15:0] stable_cnt, stable_cnt_nx;
    logic [15:0] release_cnt, release_cnt_nx;
    logic [3:0]  code_q, code_nx;
    logic [15:0] entry_nx, pin_out_nx;
    logic [2:0]  entry_cnt_nx;
    logic        pin_ready_nx, key_accept_nx, key_err_nx;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path can leave it unassigned and infer a latch.
        state_nx       = state;
        stable_cnt_nx  = stable_cnt;
        release_cnt_nx = release_cnt;
        code_nx        = code_q;
        entry_nx       = entry;
        entry_cnt_nx   = entry_cnt;
        pin_out_nx     = pin_out;
        pin_ready_nx   = 1'b0;
        key_accept_nx  = 1'b0;
        key_err_nx     = 1'b0;

        unique case (state)
            IDLE: begin
                if (key_valid) begin
                    code_nx       = key_code;
                    stable_cnt_nx = 16'd1;
                    state_nx      = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!key_valid || key_code != code_q) begin
                    stable_cnt_nx = 16'd0;
                    state_nx      = IDLE;
                end else begin
                    stable_cnt_nx = sat_inc(stable_cnt);
                    if (stable_cnt_nx >= DB_LIMIT) begin
                        key_accept_nx  = 1'b1;
                        release_cnt_nx = 16'd0;
                        state_nx       = HELD;
                    end
                end
            end
            HELD: begin
                // Code changes are ignored here; only a sustained release re-arms the debouncer.
                if (key_valid) begin
                    release_cnt_nx = 16'd0;
                end else begin
                    release_cnt_nx = sat_inc(release_cnt);
                    if (release_cnt_nx >= DB_LIMIT) begin
                        release_cnt_nx = 16'd0;
                        state_nx       = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        if (key_accept_nx) begin
            if (code_q <= 4'd9) begin
                if (entry_cnt == 3'd4) begin
                    key_err_nx = 1'b1;
                end else begin
                    entry_nx     = {entry[11:0], code_q};
                    entry_cnt_nx = entry_cnt + 3'd1;
                end
            end else if (code_q == CODE_STAR) begin
                entry_nx     = 16'd0;
                entry_cnt_nx = 3'd0;
            end else if (code_q == CODE_HASH) begin
                if (entry_cnt == 3'd4) begin
                    pin_out_nx   = entry;
                    pin_ready_nx = 1'b1;
                end else begin
                    key_err_nx = 1'b1;
                end
                entry_nx     = 16'd0;
                entry_cnt_nx = 3'd0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            stable_cnt  <= 16'd0;
            release_cnt <= 16'd0;
            code_q      <= 4'd0;
            entry       <= 16'd0;
            entry_cnt   <= 3'd0;
            pin_out     <= 16'd0;
            pin_ready   <= 1'b0;
            key_accept  <= 1'b0;
            key_err     <= 1'b0;
        end else begin
            state       <= state_nx;
            stable_cnt  <= stable_cnt_nx;
            release_cnt <= release_cnt_nx;
            code_q      <= code_nx;
            entry       <= entry_nx;
            entry_cnt   <= entry_cnt_nx;
            pin_out     <= pin_out_nx;
            pin_ready   <= pin_ready_nx;
            key_accept  <= key_accept_nx;
            key_err     <= key_err_nx;
        end
    end

endmodule

// File: tb/tb_key_entry.sv
// Self-checking bench for key_entry: press table, corner-case sequences and
// randomized key activity compared each cycle against a queue-based model.
module tb_key_entry;

    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] entry;
    logic [2:0]  entry_cnt;
    logic [15:0] pin_out;
    logic        pin_ready, key_accept, key_err;

    key_entry #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .entry      (entry),
        .entry_cnt  (entry_cnt),
        .pin_out    (pin_out),
        .pin_ready  (pin_ready),
        .key_accept (key_accept),
        .key_err    (key_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_accepts = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the press detector counts runs of matching samples,
    // the entry buffer is a queue of digits, oldest first.
    bit          m_held;
    int          m_run, m_zeros;
    logic [3:0]  m_code;
    logic [3:0]  m_q[$];
    logic [15:0] m_pin;
    bit          m_acc, m_err, m_rdy;

    function automatic logic [15:0] m_entry();
        logic [15:0] v = 16'd0;
        foreach (m_q[i]) v = {v[11:0], m_q[i]};
        return v;
    endfunction

    task automatic model_reset();
        m_held = 0; m_run = 0; m_zeros = 0; m_code = 4'd0;
        m_q.delete(); m_pin = 16'd0;
        m_acc = 0; m_err = 0; m_rdy = 0;
    endtask

    task automatic model_action(input logic [3:0] c);
        m_acc = 1;
        if (c <= 4'd9) begin
            if (m_q.size() < 4) m_q.push_back(c);
            else m_err = 1;
        end else if (c == 4'd13) begin
            m_q.delete();
        end else if (c == 4'd14) begin
            if (m_q.size() == 4) begin
                m_pin = m_entry();
                m_rdy = 1;
            end else begin
                m_err = 1;
            end
            m_q.delete();
        end
    endtask

    task automatic model_step(input logic v, input logic [3:0] c);
        m_acc = 0; m_err = 0; m_rdy = 0;
        if (!rst_n) begin
            model_reset();
        end else if (m_held) begin
            if (v) m_zeros = 0;
            else begin
                m_zeros++;
                if (m_zeros == DC) begin m_held = 0; m_zeros = 0; end
            end
        end else if (m_run == 0) begin
            if (v) begin m_run = 1; m_code = c; end
        end else if (v && c == m_code) begin
            m_run++;
            if (m_run == DC) begin
                m_run = 0; m_held = 1; m_zeros = 0;
                model_action(m_code);
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic tick(input logic v, input logic [3:0] c);
        key_valid = v;
        key_code  = c;
        @(posedge clk);
        #1;
        model_step(v, c);
        check("m_entry",      entry,      m_entry());
        check("m_entry_cnt",  entry_cnt,  m_q.size());
        check("m_pin_out",    pin_out,    m_pin);
        check("m_pin_ready",  pin_ready,  m_rdy);
        check("m_key_accept", key_accept, m_acc);
        check("m_key_err",    key_err,    m_err);
        if (key_accept === 1'b1) n_accepts++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_entry"},      entry,      0);
        check({tag, "_entry_cnt"},  entry_cnt,  0);
        check({tag, "_pin_out"},    pin_out,    0);
        check({tag, "_pin_ready"},  pin_ready,  0);
        check({tag, "_key_accept"}, key_accept, 0);
        check({tag, "_key_err"},    key_err,    0);
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        model_reset();
    endtask

    logic [15:0] snap_entry, snap_pin;
    logic [2:0]  snap_cnt;
    logic        snap_acc, snap_err, snap_rdy;

    task automatic press(input logic [3:0] c, input int hold, input int rel);
        for (int i = 1; i <= hold; i++) begin
            tick(1'b1, c);
            if (i == DC) begin
                snap_entry = entry; snap_cnt = entry_cnt; snap_pin = pin_out;
                snap_acc = key_accept; snap_err = key_err; snap_rdy = pin_ready;
            end
        end
        for (int i = 0; i < rel; i++) tick(1'b0, 4'd0);
    endtask

    typedef struct {
        logic [3:0]  code;
        logic [15:0] exp_entry;
        logic [2:0]  exp_cnt;
        logic [15:0] exp_pin;
        logic        exp_err;
        logic        exp_rdy;
    } press_t;

    press_t vec[22];

    initial begin
        int a0;
        logic [3:0] rc;
        logic rv;
        int rlen;

        vec[0]  = '{4'd13, 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b0};
        vec[1]  = '{4'd1,  16'h0001, 3'd1, 16'h0000, 1'b0, 1'b0};
        vec[2]  = '{4'd2,  16'h0012, 3'd2, 16'h0000, 1'b0, 1'b0};
        vec[3]  = '{4'd3,  16'h0123, 3'd3, 16'h0000, 1'b0, 1'b0};
        vec[4]  = '{4'd4,  16'h1234, 3'd4, 16'h0000, 1'b0, 1'b0};
        vec[5]  = '{4'd14, 16'h0000, 3'd0, 16'h1234, 1'b0, 1'b1};
        vec[6]  = '{4'd9,  16'h0009, 3'd1, 16'h1234, 1'b0, 1'b0};
        vec[7]  = '{4'd8,  16'h0098, 3'd2, 16'h1234, 1'b0, 1'b0};
        vec[8]  = '{4'd7,  16'h0987, 3'd3, 16'h1234, 1'b0, 1'b0};
        vec[9]  = '{4'd6,  16'h9876, 3'd4, 16'h1234, 1'b0, 1'b0};
        vec[10] = '{4'd5,  16'h9876, 3'd4, 16'h1234, 1'b1, 1'b0};
        vec[11] = '{4'd13, 16'h0000, 3'd0, 16'h1234, 1'b0, 1'b0};
        vec[12] = '{4'd1,  16'h0001, 3'd1, 16'h1234, 1'b0, 1'b0};
        vec[13] = '{4'd14, 16'h0000, 3'd0, 16'h1234, 1'b1, 1'b0};
        vec[14] = '{4'd15, 16'h0000, 3'd0, 16'h1234, 1'b0, 1'b0};
        vec[15] = '{4'd10, 16'h0000, 3'd0, 16'h1234, 1'b0, 1'b0};
        vec[16] = '{4'd12, 16'h0000, 3'd0, 16'h1234, 1'b0, 1'b0};
        vec[17] = '{4'd5,  16'h0005, 3'd1, 16'h1234, 1'b0, 1'b0};
        vec[18] = '{4'd6,  16'h0056, 3'd2, 16'h1234, 1'b0, 1'b0};
        vec[19] = '{4'd7,  16'h0567, 3'd3, 16'h1234, 1'b0, 1'b0};
        vec[20] = '{4'd8,  16'h5678, 3'd4, 16'h1234, 1'b0, 1'b0};
        vec[21] = '{4'd14, 16'h0000, 3'd0, 16'h5678, 1'b0, 1'b1};

        rst_n = 1'b0; key_valid = 1'b0; key_code = 4'd0;
        model_reset();
        #12;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(1'b0, 4'd0);
        check_all_zero("post_reset");

        // Short bounce, gap, then a clean press of 7.
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 4'd7);
            check("bounce_no_accept", key_accept, 0);
        end
        for (int i = 0; i < 5; i++) tick(1'b0, 4'd0);
        a0 = n_accepts;
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, 4'd7);
            if (i == DC) check("deb_accept_edge", key_accept, 1);
        end
        check("deb_accept_count", n_accepts - a0, 1);
        check("deb_entry", entry, 16'h0007);
        check("deb_entry_cnt", entry_cnt, 1);
        for (int i = 0; i <= DC; i++) tick(1'b0, 4'd0);

        for (int i = 0; i < $size(vec); i++) begin
            a0 = n_accepts;
            press(vec[i].code, DC + 3, DC + 1);
            check($sformatf("vec%0d_entry", i),     snap_entry, vec[i].exp_entry);
            check($sformatf("vec%0d_cnt", i),       snap_cnt,   vec[i].exp_cnt);
            check($sformatf("vec%0d_pin", i),       snap_pin,   vec[i].exp_pin);
            check($sformatf("vec%0d_accept", i),    snap_acc,   1);
            check($sformatf("vec%0d_err", i),       snap_err,   vec[i].exp_err);
            check($sformatf("vec%0d_ready", i),     snap_rdy,   vec[i].exp_rdy);
            check($sformatf("vec%0d_n_accept", i),  n_accepts - a0, 1);
        end

        // No-function code held for 10 edges.
        a0 = n_accepts;
        press(4'd15, 10, DC + 1);
        check("nofunc_n_accept", n_accepts - a0, 1);
        check("nofunc_entry", entry, 16'h0000);
        check("nofunc_pin", pin_out, 16'h5678);

        // Bounce from 2 to 3 before acceptance: only 3 is taken.
        a0 = n_accepts;
        for (int i = 0; i < 2; i++) tick(1'b1, 4'd2);
        for (int i = 0; i < 10; i++) tick(1'b1, 4'd3);
        for (int i = 0; i <= DC; i++) tick(1'b0, 4'd0);
        check("bounce23_n_accept", n_accepts - a0, 1);
        check("bounce23_entry", entry, 16'h0003);

        // Code change while held: no second action.
        a0 = n_accepts;
        for (int i = 0; i < DC; i++) tick(1'b1, 4'd2);
        for (int i = 0; i < 8; i++) tick(1'b1, 4'd3);
        for (int i = 0; i <= DC; i++) tick(1'b0, 4'd0);
        check("held_change_n_accept", n_accepts - a0, 1);
        check("held_change_entry", entry, 16'h0032);

        // Reset in HELD with two digits entered, key still down afterwards.
        press(4'd13, DC, DC + 1);
        press(4'd4, DC, DC + 1);
        for (int i = 0; i < DC + 2; i++) tick(1'b1, 4'd5);
        check("held_entry_cnt", entry_cnt, 2);
        assert_reset();
        tick(1'b1, 4'd5);
        tick(1'b1, 4'd5);
        check_all_zero("in_reset");
        #3 rst_n = 1'b1;
        for (int i = 1; i <= DC; i++) begin
            tick(1'b1, 4'd5);
            check($sformatf("rehold_accept_%0d", i), key_accept, (i == DC) ? 1 : 0);
        end
        check("rehold_entry", entry, 16'h0005);
        for (int i = 0; i <= DC; i++) tick(1'b0, 4'd0);

        // Randomized activity against the model.
        for (int s = 0; s < 400; s++) begin
            rv   = ($urandom_range(0, 3) != 0);
            rc   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) rc = 4'd14;
            rlen = $urandom_range(1, 9);
            if ($urandom_range(0, 99) == 0) begin
                assert_reset();
                tick(rv, rc);
                #2 rst_n = 1'b1;
            end
            for (int i = 0; i < rlen; i++) tick(rv, rc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
